// File: rtl/req_agent.sv
// req_agent: three independent request channels feeding a fixed-priority grant arbiter.
// Optional starvation watchdog is built only when REQ_AGENT_WATCHDOG_EN is defined.
module req_agent #(
    parameter int TENURE   = 4,
    parameter int DEPTH    = 7,
    parameter int WD_LIMIT = 64,
    localparam int PW      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      job_in,
    input  logic            g1,
    input  logic            g2,
    input  logic            g3,
    output logic            r1,
    output logic            r2,
    output logic            r3,
    output logic [2:0]      done,
    output logic [2:0]      ovf,
    output logic            err,
    output logic [2:0]      starve,
    output logic [5:0]      dbg_state_o,
    output logic [3*PW-1:0] dbg_pending_o
);
    // Handshake: rN is a registered level held high for the whole job; gN is
    // sampled on each rising edge and advances the job only while rN is high.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam logic [7:0]    TEN_LAST = 8'(TENURE - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(DEPTH);

    if (TENURE < 1 || TENURE > 255 || DEPTH < 1 || DEPTH > 255 || WD_LIMIT < 1) begin : g_bad_param
        $error("req_agent: parameter out of range");
    end

    logic [2:0]    g_vec;
    state_e        state_q [3];
    state_e        state_d [3];
    logic [PW-1:0] pend_q  [3];
    logic [PW-1:0] pend_d  [3];
    logic [7:0]    ten_q   [3];
    logic [7:0]    ten_d   [3];
    logic [2:0]    r_q, r_d;
    logic [2:0]    done_q, done_d;
    logic [2:0]    ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [2:0]    complete;

    assign g_vec = {g3, g2, g1};

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ten_d    = ten_q;
        r_d      = '0;
        done_d   = '0;
        ovf_d    = '0;
        complete = '0;
        // A grant to a non-requesting channel, or two grants at once, is a protocol error.
        err_d = err_q | (|(g_vec & ~r_q)) | ((g_vec & (g_vec - 3'd1)) != 3'd0);

        for (int ch = 0; ch < 3; ch++) begin
            complete[ch] = (state_q[ch] == ST_ACTIVE) && g_vec[ch] && (ten_q[ch] == TEN_LAST);
            ovf_d[ch]    = job_in[ch] && (pend_q[ch] == PEND_MAX) && !complete[ch];

            if (job_in[ch] && !ovf_d[ch] && !complete[ch]) begin
                pend_d[ch] = pend_q[ch] + 1'b1;
            end else if (complete[ch] && !job_in[ch]) begin
                pend_d[ch] = pend_q[ch] - 1'b1;
            end

            case (state_q[ch])
                ST_IDLE: begin
                    if (pend_q[ch] != '0 || job_in[ch]) begin
                        state_d[ch] = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (complete[ch]) begin
                        ten_d[ch]   = '0;
                        state_d[ch] = ST_GAP;
                    end else if (g_vec[ch]) begin
                        ten_d[ch] = ten_q[ch] + 8'd1;
                    end
                end
                ST_GAP: begin
                    state_d[ch] = (pend_d[ch] != '0) ? ST_ACTIVE : ST_IDLE;
                end
                default: begin
                    state_d[ch] = ST_IDLE;
                end
            endcase

            r_d[ch]    = (state_d[ch] == ST_ACTIVE);
            done_d[ch] = complete[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                state_q[ch] <= ST_IDLE;
                pend_q[ch]  <= '0;
                ten_q[ch]   <= '0;
            end
            r_q    <= '0;
            done_q <= '0;
            ovf_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ten_q   <= ten_d;
            r_q     <= r_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

`ifdef REQ_AGENT_WATCHDOG_EN
    localparam int            WW     = $clog2(WD_LIMIT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WD_LIMIT);

    logic [WW-1:0] wd_q [3];
    logic [WW-1:0] wd_d [3];
    logic [2:0]    starve_q, starve_d;

    // Counts consecutive requested-but-ungranted cycles; saturates at the limit.
    always_comb begin
        wd_d     = wd_q;
        starve_d = starve_q;
        for (int ch = 0; ch < 3; ch++) begin
            if (r_q[ch] && !g_vec[ch]) begin
                wd_d[ch] = (wd_q[ch] == WD_MAX) ? wd_q[ch] : wd_q[ch] + 1'b1;
            end else begin
                wd_d[ch] = '0;
            end
            if (wd_d[ch] == WD_MAX) begin
                starve_d[ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                wd_q[ch] <= '0;
            end
            starve_q <= '0;
        end else begin
            wd_q     <= wd_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = '0;
`endif

    assign r1            = r_q[0];
    assign r2            = r_q[1];
    assign r3            = r_q[2];
    assign done          = done_q;
    assign ovf           = ovf_q;
    assign err           = err_q;
    assign dbg_state_o   = {state_q[2], state_q[1], state_q[0]};
    assign dbg_pending_o = {pend_q[2], pend_q[1], pend_q[0]};

endmodule

// File: tb/tb_req_agent.sv
// Directed bench for req_agent with a done-pulse scoreboard and a fixed-priority arbiter model.
module tb_req_agent;
    localparam int TENURE   = 4;
    localparam int DEPTH    = 7;
    localparam int WD_LIMIT = 64;
    localparam int PW       = $clog2(DEPTH + 1);
`ifdef REQ_AGENT_WATCHDOG_EN
    localparam logic [2:0] STARVE_EXP = 3'b100;
`else
    localparam logic [2:0] STARVE_EXP = 3'b000;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      job_in;
    logic            g1, g2, g3;
    logic            r1, r2, r3;
    logic [2:0]      done, ovf, starve;
    logic            err;
    logic [5:0]      dbg_state;
    logic [3*PW-1:0] dbg_pending;

    logic            mode;
    logic [2:0]      g_force;
    logic [2:0]      exp_q[$];
    int              vec_cnt = 0;
    int              err_cnt = 0;

    // Arbiter model: fixed priority r1 > r2 > r3, or forced grants when mode=1.
    assign g1 = mode ? g_force[0] : r1;
    assign g2 = mode ? g_force[1] : (r2 & ~r1);
    assign g3 = mode ? g_force[2] : (r3 & ~r1 & ~r2);

    always #5 clk = ~clk;

    req_agent #(.TENURE(TENURE), .DEPTH(DEPTH), .WD_LIMIT(WD_LIMIT)) dut (
        .clk(clk), .rst(rst), .job_in(job_in),
        .g1(g1), .g2(g2), .g3(g3),
        .r1(r1), .r2(r2), .r3(r3),
        .done(done), .ovf(ovf), .err(err), .starve(starve),
        .dbg_state_o(dbg_state), .dbg_pending_o(dbg_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst === 1'b0 && done !== 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_sb", 32'(done), 32'(e));
            end
        end
    end

    initial begin
        int ch;
        rst = 1'b1; job_in = '0; mode = 1'b0; g_force = '0;
        repeat (3) tick();
        chk("rst_r", 32'({r3, r2, r1}), 32'd0);
        chk("rst_done_ovf", 32'({done, ovf}), 32'd0);
        chk("rst_err_starve", 32'({err, starve}), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();

        // Single job on channel 1 with loopback grants.
        job_in = 3'b001; exp_q.push_back(3'b001);
        tick();
        job_in = '0;
        chk("sj_r1_c1", 32'(r1), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("sj_r1_hold", 32'(r1), 32'd1);
        end
        tick();
        chk("sj_done", 32'(done), 32'b001);
        chk("sj_r1_gap", 32'(r1), 32'd0);
        chk("sj_state_gap", 32'(dbg_state[1:0]), 32'd2);
        tick();
        chk("sj_state_idle", 32'(dbg_state[1:0]), 32'd0);
        chk("sj_done_clr", 32'(done), 32'd0);

        // Preemption: channel 3 gets two grants, then channel 1 takes over.
        job_in = 3'b100;
        tick();
        job_in = '0;
        tick();
        job_in = 3'b001; exp_q.push_back(3'b001); exp_q.push_back(3'b100);
        tick();
        job_in = '0;
        chk("pre_r1", 32'(r1), 32'd1);
        chk("pre_r3_held", 32'(r3), 32'd1);
        repeat (3) begin
            tick();
            chk("pre_no_done", 32'(done), 32'd0);
        end
        tick();
        chk("pre_done_ch1", 32'(done), 32'b001);
        chk("pre_r1_low", 32'(r1), 32'd0);
        tick();
        chk("pre_ch3_wait", 32'({done, r3}), 32'b0001);
        tick();
        chk("pre_done_ch3", 32'(done), 32'b100);
        chk("pre_r3_low", 32'(r3), 32'd0);
        tick();

        // Overflow on channel 2 with all grants blocked.
        mode = 1'b1; g_force = '0;
        for (int i = 1; i <= 8; i++) begin
            job_in = 3'b010;
            tick();
            chk("ovf_pulse", 32'(ovf), (i == 8) ? 32'b010 : 32'd0);
        end
        job_in = '0;
        tick();
        chk("ovf_clr", 32'(ovf), 32'd0);
        chk("ovf_pend", 32'(dbg_pending[2*PW-1:PW]), 32'(DEPTH));
        chk("ovf_no_err", 32'(err), 32'd0);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(3'b010);
        mode = 1'b0;
        repeat (DEPTH * (TENURE + 1) + 3) tick();
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);
        chk("ovf_idle", 32'(dbg_state), 32'd0);

        // Random single-channel jobs.
        for (int k = 0; k < 6; k++) begin
            ch = $urandom_range(0, 2);
            job_in = 3'(1 << ch); exp_q.push_back(3'(1 << ch));
            tick();
            job_in = '0;
            chk("rnd_req", 32'({r3, r2, r1}), 32'(1 << ch));
            repeat (TENURE + 2) tick();
            chk("rnd_idle", 32'({r3, r2, r1}), 32'd0);
        end

        // Protocol error: grant without request, then sticky until reset.
        mode = 1'b1; g_force = 3'b010;
        tick();
        g_force = '0;
        chk("err_set", 32'(err), 32'd1);
        repeat (3) tick();
        chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("err_rst", 32'(err), 32'd0);

        // Protocol error: two grants to two requesting channels.
        job_in = 3'b101;
        tick();
        job_in = '0;
        tick();
        chk("err_multi_pre", 32'(err), 32'd0);
        g_force = 3'b101;
        tick();
        g_force = '0;
        chk("err_multi", 32'(err), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;

        // Starvation: channel 3 requests with no grant.
        job_in = 3'b100;
        tick();
        job_in = '0;
        repeat (WD_LIMIT - 1) tick();
        chk("starve_early", 32'(starve), 32'd0);
        tick();
        chk("starve_set", 32'(starve), 32'(STARVE_EXP));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("starve_rst", 32'(starve), 32'd0);

        // Reset mid-job with three pending on channel 1.
        g_force = '0;
        repeat (3) begin
            job_in = 3'b001;
            tick();
        end
        job_in = '0;
        mode = 1'b0;
        repeat (2) tick();
        chk("rmj_pend", 32'(dbg_pending[PW-1:0]), 32'd3);
        rst = 1'b1;
        tick();
        chk("rmj_outs", 32'({r3, r2, r1, done, ovf, err, starve}), 32'd0);
        chk("rmj_pend_clr", 32'(dbg_pending), 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        chk("rmj_idle", 32'({dbg_state, r3, r2, r1}), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/req_agent.md
# req_agent

Requester-side companion to the three-way fixed-priority grant arbiter. The block holds three independent request channels. For each channel it queues incoming jobs, drives the channel's request line r1..r3 toward the arbiter and consumes the matching grant g1..g3. Each job completes after TENURE granted cycles; the channel then drops its request for one cycle so lower-priority channels get in. It also flags protocol errors on the grant bus.

## Interface
- TENURE, 4: granted cycles needed to complete one job (1..255)
- DEPTH, 7: maximum pending jobs per channel (1..255)
- WD_LIMIT, 64: starvation threshold in cycles; used only with REQ_AGENT_WATCHDOG_EN
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- job_in  in  3  bit n-1 = one new job for channel n, one per cycle per bit
- g1, g2, g3  in  1  grants from the arbiter, combinational on r1..r3
- r1, r2, r3  out  1  requests to the arbiter, registered
- done  out  3  one-cycle pulse per completed job (bit n-1 = channel n)
- ovf  out  3  one-cycle pulse: job dropped because the queue was full
- err  out  1  sticky protocol error
- starve  out  3  sticky starvation flags

## Operation
- Each channel has:
  - a pending counter, $clog2(DEPTH+1) bits wide
  - a tenure counter, 8 bits wide
  - a state: IDLE, ACTIVE or GAP
- Job accepted (job_in bit set):
  - pending increments, unless pending==DEPTH and no completion happens in the same cycle.
  - In that full case the job is dropped and ovf pulses for that channel.
  - Accept and completion in the same cycle leave pending unchanged.
- State transitions:
  - IDLE: rN=0. Goes to ACTIVE when pending>0, or when a job arrives this cycle.
  - ACTIVE: rN=1. Each cycle with gN=1 increments the tenure counter; cycles with gN=0 pause it.
  - On the TENURE-th granted cycle: pending decrements, tenure clears, state goes to GAP.
  - GAP: rN=0 for exactly one cycle. Goes to ACTIVE if pending>0, otherwise IDLE.
- Preemption by a higher-priority channel is legal. The preempted job resumes counting when its grant returns; no progress is lost.
- err sets on any of these, and stays set until rst:
  - gN=1 while rN=0
  - more than one of g1..g3 high in the same cycle
- Reset outputs: r1..r3=0, done=0, ovf=0, err=0, starve=0. All counters clear and every channel goes to IDLE.
- Reset mid-job abandons the job and all pending jobs, with no done pulse.

## Timing
- job_in in cycle t, with the channel IDLE: rN high from cycle t+1.
- Completion on the granted cycle c: done pulses in cycle c+1, rN=0 in cycle c+1, and rN is high again in c+2 if jobs remain.
- Minimum period per job with an uncontended grant: TENURE+1 cycles.
- ovf pulses in the cycle after the rejected job_in.
- err is high from the cycle after the offending grant.
- Counter arithmetic is unsigned and never wraps:
  - pending saturates at DEPTH (overflow is dropped).
  - tenure resets at TENURE.

## Configuration
- REQ_AGENT_WATCHDOG_EN defined:
  - Each channel counts consecutive cycles with rN=1 and gN=0. The count clears on any grant or when rN=0.
  - When the count reaches WD_LIMIT, starve[n-1] sets and stays set until rst.
- Not defined: no watchdog logic is built, and starve is tied to 0.

## Test plan
- Single job, loopback arbiter (gN=rN), TENURE=4: job_in=3'b001 in cycle 0 -> r1 high in cycles 1-4, done=3'b001 in cycle 5, r1 low in 5, IDLE in 6.
- Preemption: channel 3 is ACTIVE with 2 granted cycles done; job on channel 1 -> g3 drops, channel 3 tenure holds at 2, channel 3 resumes after channel 1's GAP and completes after 2 more grants.
- Overflow, DEPTH=7: 8 back-to-back jobs on channel 2 with grants blocked -> pending=7, ovf=3'b010 on the 8th, no done.
- Protocol error: force g2=1 while r2=0 -> err=1 next cycle and stays 1 until rst; second test with g1 and g3 both high -> err=1.
- Starvation (macro on, WD_LIMIT=64): channel 3 requests while channel 1 is held continuously -> starve=3'b100 after 64 ungranted cycles; with the macro off, starve stays 0.
- Reset mid-job: rst high during ACTIVE with pending=3 -> all outputs 0 the next cycle, no done, IDLE after release.
